mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_divider.sv | 46 ++++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   mdu_op_e    : 4-bit operation codes issued by the EX stage
//   MUL_LAT     : busy cycles for MULT/MULTU (and MADD family when enabled)
//   DIV_LAT     : busy cycles for DIV/DIVU
//   mdu_state_e : control state (IDLE, RUN)
//   mdu_dbg_t   : debug view of the control state, counter and captured op
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MUL_LAT = 4'd5;
  localparam logic [CNT_W-1:0] DIV_LAT = 4'd10;
  localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    mdu_state_e      state;
    logic [CNT_W-1:0] cnt;
    mdu_op_e         op;
  } mdu_dbg_t;

  // Ops whose product is formed from sign-extended operands.
  function automatic logic is_signed_mul(input mdu_op_e o);
    return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider -- 32-bit signed/unsigned quotient and remainder.
//   a, b        : dividend and divisor (held stable by the caller for the
//                 whole DIV_LAT window, so this is a multicycle path)
//   is_signed   : 1 = two's-complement divide, 0 = unsigned
//   quotient    : truncated toward zero
//   remainder   : carries the sign of the dividend
//   div_by_zero : b == 0; quotient/remainder are meaningless and must not
//                 be committed
module mdu_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_b_safe;
  logic [31:0] uq;
  logic [31:0] ur;

  assign neg_a = is_signed & a[31];
  assign neg_b = is_signed & b[31];

  // Magnitudes. 0x80000000 negates to itself, which is its correct
  // unsigned magnitude, so the most-negative dividend needs no special path.
  assign mag_a = neg_a ? (~a + 32'd1) : a;
  assign mag_b = neg_b ? (~b + 32'd1) : b;

  assign div_by_zero = (b == 32'd0);
  // Keep the datapath well-defined on a zero divisor; the result is dropped.
  assign mag_b_safe  = div_by_zero ? 32'd1 : mag_b;

  assign uq = mag_a / mag_b_safe;
  assign ur = mag_a % mag_b_safe;

  // 0x80000000 / -1: magnitudes give 0x80000000 / 1, signs agree, so the
  // quotient stays 0x80000000 and the remainder 0 -- the wrapped result.
  assign quotient  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign remainder = neg_a ? (~ur + 32'd1) : ur;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit -- multicycle multiply/divide unit owning HI and LO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start, op  : issue strobe and op code from EX (one cycle)
//   cancel     : flushes the instruction issued in the same cycle
//   a, b       : rs / rt operands, captured at acceptance
//   busy       : high while a MULT/DIV-class op is in flight
//   hi, lo     : architectural HI / LO registers
//   dbg        : control state, down-counter and captured op
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// without it those codes behave as no-ops.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_dbg_t    dbg
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        accept;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  // Handshake: start is the valid, !busy is the ready; an op is taken on a
  // rising edge where both hold and cancel is low. Nothing else is buffered.
  assign accept = start & ~cancel & (state_q == ST_IDLE);

  // Low 64 bits of the 64x64 product of the extended operands equal the
  // signed or unsigned 32x32 product.
  assign ext_a = is_signed_mul(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b = is_signed_mul(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = ext_a * ext_b;

  mdu_divider u_divider (
    .a           (a_q),
    .b           (b_q),
    .is_signed   (op_q == OP_DIV),
    .quotient    (quot),
    .remainder   (rem),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
            , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
            : begin
              state_d = ST_RUN;
              cnt_d   = MUL_LAT;
              op_d    = mdu_op_e'(op);
              a_d     = a;
              b_d     = b;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = DIV_LAT;
              op_d    = mdu_op_e'(op);
              a_d     = a;
              b_d     = b;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_DIV, OP_DIVU: begin
              if (!div_by_zero) begin
                lo_d = quot;
                hi_d = rem;
              end
            end
`ifdef MDU_MADD_EN
            // Accumulate against HI/LO as they stand at the commit edge.
            OP_MADD, OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
            default: ;
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign dbg.state = state_q;
  assign dbg.cnt   = cnt_q;
  assign dbg.op    = op_q;

endmodule
